// File: rtl/qeciphy_bufg_gt_ctrl_pkg.sv
// Shared types and constants for the BUFG_GT control driver.
package qeciphy_bufg_gt_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_SRC = 2'd0,
        CLR_HOLD = 2'd1,
        SETTLE   = 2'd2,
        STABLE   = 2'd3
    } state_t;

    typedef logic [2:0] div_code_t;

    localparam int MIN_CLR_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qeciphy_bufg_gt_ctrl_sync_2ff.sv
// Two-flop synchronizer for src_ready; only present when QECIPHY_BUFG_GT_CTRL_SYNC_EN is defined.
`ifdef QECIPHY_BUFG_GT_CTRL_SYNC_EN
module qeciphy_sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`endif

// File: rtl/qeciphy_bufg_gt_ctrl.sv
// BUFG_GT CE/CLR/DIV sequencer with divide-change handshake and clock-stable report.
// Optional src_ready synchronizer enabled by defining QECIPHY_BUFG_GT_CTRL_SYNC_EN.
module qeciphy_bufg_gt_ctrl
    import qeciphy_bufg_gt_ctrl_pkg::*;
#(
    parameter int        CLR_CYCLES    = 8,
    parameter int        SETTLE_CYCLES = 64,
    parameter div_code_t DIV_RESET     = 3'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_src_ready,
    input  logic [2:0] i_div_req,
    input  logic       i_div_req_valid,
    output logic       o_div_req_ready,
    output logic       o_bufg_ce,
    output logic       o_bufg_cemask,
    output logic       o_bufg_clr,
    output logic       o_bufg_clrmask,
    output logic [2:0] o_bufg_div,
    output logic       o_clk_stable
);

    localparam int CNT_W = $clog2(max_int(CLR_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    generate
        if (CLR_CYCLES < MIN_CLR_CYCLES || SETTLE_CYCLES < 1) begin : g_param_check
            $error("qeciphy_bufg_gt_ctrl: CLR_CYCLES must be >= 2 and SETTLE_CYCLES >= 1");
        end
    endgenerate

    logic w_src;

`ifdef QECIPHY_BUFG_GT_CTRL_SYNC_EN
    qeciphy_sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_src_ready),
        .o_q     (w_src)
    );
`else
    assign w_src = i_src_ready;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    div_code_t        r_pend;
    div_code_t        r_div;
    logic             r_clr;
    logic             r_ce;
    logic             r_stable;
    logic             r_ready;
    logic             w_accept;

    assign w_accept = i_div_req_valid && r_ready;

    // Sequencer: source loss always forces WAIT_SRC; DIV only moves inside CLR_HOLD while CLR is high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= WAIT_SRC;
            r_cnt    <= '0;
            r_pend   <= DIV_RESET;
            r_div    <= DIV_RESET;
            r_clr    <= 1'b1;
            r_ce     <= 1'b0;
            r_stable <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend <= i_div_req;
            end
            if (r_state != WAIT_SRC && !w_src) begin
                r_state  <= WAIT_SRC;
                r_cnt    <= '0;
                r_clr    <= 1'b1;
                r_ce     <= 1'b0;
                r_stable <= 1'b0;
                r_ready  <= 1'b1;
            end else begin
                case (r_state)
                    WAIT_SRC: begin
                        if (w_src) begin
                            r_state <= CLR_HOLD;
                            r_cnt   <= CLR_LOAD;
                            r_ready <= 1'b0;
                        end else begin
                            r_ready <= 1'b1;
                        end
                    end
                    CLR_HOLD: begin
                        if (r_cnt == CLR_LOAD) begin
                            r_div <= r_pend;
                        end
                        if (r_cnt == CNT_ONE) begin
                            r_state <= SETTLE;
                            r_cnt   <= SETTLE_LOAD;
                            r_clr   <= 1'b0;
                            r_ce    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    SETTLE: begin
                        if (r_cnt == CNT_ONE) begin
                            r_state  <= STABLE;
                            r_stable <= 1'b1;
                            r_ready  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    STABLE: begin
                        if (w_accept) begin
                            r_state  <= CLR_HOLD;
                            r_cnt    <= CLR_LOAD;
                            r_clr    <= 1'b1;
                            r_ce     <= 1'b0;
                            r_stable <= 1'b0;
                            r_ready  <= 1'b0;
                        end else begin
                            r_stable <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= WAIT_SRC;
                        r_cnt    <= '0;
                        r_clr    <= 1'b1;
                        r_ce     <= 1'b0;
                        r_stable <= 1'b0;
                        r_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_div_req_ready = r_ready;
    assign o_bufg_ce       = r_ce;
    assign o_bufg_cemask   = 1'b0;
    assign o_bufg_clr      = r_clr;
    assign o_bufg_clrmask  = 1'b0;
    assign o_bufg_div      = r_div;
    assign o_clk_stable    = r_stable;

endmodule

// File: tb/tb_qeciphy_bufg_gt_ctrl.sv
// Scoreboard bench for qeciphy_bufg_gt_ctrl: timeline reference model, directed scenarios, random stimulus.
module tb_qeciphy_bufg_gt_ctrl;

    localparam int CLR  = 8;
    localparam int SET  = 64;
    localparam int FULL = CLR + SET;
`ifdef QECIPHY_BUFG_GT_CTRL_SYNC_EN
    localparam int EXP_LAT = 75;
`else
    localparam int EXP_LAT = 73;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       src;
    logic [2:0] req;
    logic       valid;
    logic       ready, ce, cemask, clr, clrmask, stable;
    logic [2:0] div;

    always #5 clk = ~clk;

    qeciphy_bufg_gt_ctrl dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_src_ready     (src),
        .i_div_req       (req),
        .i_div_req_valid (valid),
        .o_div_req_ready (ready),
        .o_bufg_ce       (ce),
        .o_bufg_cemask   (cemask),
        .o_bufg_clr      (clr),
        .o_bufg_clrmask  (clrmask),
        .o_bufg_div      (div),
        .o_clk_stable    (stable)
    );

    typedef struct {
        logic       clr;
        logic       ce;
        logic       stable;
        logic       ready;
        logic [2:0] div;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: seq counts cycles since the clear sequence started (-1 = waiting for source).
    int   m_seq = -1;
    int   m_div = 0;
    int   m_pend = 0;
    bit   m_rdy = 1'b0;
    bit   s1 = 1'b0, s2 = 1'b0;

    always @(posedge clk) begin
        bit   se;
        bit   acc;
        exp_t e;
        if (!rst_n) begin
            m_seq = -1; m_div = 0; m_pend = 0; m_rdy = 1'b0; s1 = 1'b0; s2 = 1'b0;
        end else begin
`ifdef QECIPHY_BUFG_GT_CTRL_SYNC_EN
            se = s2; s2 = s1; s1 = src;
`else
            se = src;
`endif
            acc = valid && m_rdy;
            if (m_seq < 0) begin
                if (se) m_seq = 0;
                m_rdy = !se;
            end else if (!se) begin
                m_seq = -1;
                m_rdy = 1'b1;
            end else if (m_seq >= FULL) begin
                if (acc) begin
                    m_seq = 0;
                    m_rdy = 1'b0;
                end
            end else begin
                if (m_seq == 0) m_div = m_pend;
                m_seq++;
                m_rdy = (m_seq >= FULL);
            end
            if (acc) m_pend = int'(req);
        end
        e.clr    = (m_seq < 0) || (m_seq < CLR);
        e.ce     = !e.clr;
        e.stable = (m_seq >= FULL);
        e.ready  = m_rdy;
        e.div    = 3'(m_div);
        q.push_back(e);
    end

    logic       prev_clr = 1'b1;
    logic [2:0] prev_div = 3'd0;

    // Monitor: compares every cycle's outputs against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("clr", int'(clr), int'(e.clr));
            chk("ce", int'(ce), int'(e.ce));
            chk("clk_stable", int'(stable), int'(e.stable));
            chk("div_req_ready", int'(ready), int'(e.ready));
            chk("bufg_div", int'(div), int'(e.div));
        end
        chk("masks_zero", int'({cemask, clrmask}), 0);
        if (div != prev_div && rst_n) chk("div_change_with_clr_high", int'({prev_clr, clr}), 3);
        prev_clr = clr;
        prev_div = div;
    end

    task automatic wait_stable(input int bound);
        int n;
        n = 0;
        while (!stable && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!stable) chk("wait_stable_timeout", 0, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; src = 1'b0; valid = 1'b0; req = 3'd0;
        repeat (3) @(negedge clk);
        src = 1'b1; rst_n = 1'b1;

        // start-up latency
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!stable && n < 200);
        chk("startup_latency", n, EXP_LAT);

        // divide change in STABLE
        @(negedge clk); valid = 1'b1; req = 3'd3;
        @(negedge clk); valid = 1'b0;
        wait_stable(200);

        // source loss mid-SETTLE then recovery
        @(negedge clk); valid = 1'b1; req = 3'd1;
        @(negedge clk); valid = 1'b0;
        repeat (28) @(negedge clk);
        src = 1'b0;
        repeat (10) @(negedge clk);
        src = 1'b1;
        wait_stable(200);

        // request held through CLR_HOLD/SETTLE, accepted once at STABLE
        @(negedge clk); valid = 1'b1; req = 3'd2;
        @(negedge clk); req = 3'd6;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("held_req_timeout", 0, 1);
        @(negedge clk); valid = 1'b0;
        wait_stable(200);

        // accept coincident with source loss
        @(negedge clk); valid = 1'b1; req = 3'd5; src = 1'b0;
        @(negedge clk); valid = 1'b0;
        repeat (5) @(negedge clk);
        src = 1'b1;
        wait_stable(200);

        // randomized phase
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (src) src = ($urandom_range(0, 299) != 0);
            else     src = ($urandom_range(0, 9) == 0);
            valid = ($urandom_range(0, 3) == 0);
            req   = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 1499) != 0);
        end
        rst_n = 1'b1; valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
